vx_issue_scoreboard: RTL and testbench

- Issue-stage register scoreboard between the per-warp instruction buffer and the GPR-read/dispatch stage.
- Tracks per-warp destination registers with writebacks still in flight.
- Holds any instruction with a RAW or WAW hazard, and forwards clean instructions through one registered output stage.
- Register-release events come from the commit/writeback path.

---
 rtl/vx_issue_scoreboard.sv | 160 ++++++++++++++++
 tb/tb_vx_issue_scoreboard.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : vx_issue_scoreboard
// Description : Issue-stage register scoreboard. Tracks per-warp destination
//               registers with writebacks in flight, holds instructions with
//               RAW/WAW hazards and forwards clean ones through one registered
//               output stage. Releases come from the commit/writeback path and
//               are bypassed into the same-cycle hazard check.
// Ports       : clk, reset (sync, active-low)
//               in_*   : instruction from the instruction buffer (valid/ready)
//               out_*  : registered instruction to GPR read / dispatch
//               wb_*   : register-release events (only eop releases)
//               stall_timeout : sticky, hazard stall held STALL_TIMEOUT cycles
//               perf_stalls   : wrapping count of hazard-stall cycles
// Revision    : 1.0 - initial release
// ============================================================================
module vx_issue_scoreboard #(
    parameter int NUM_WARPS     = 4,
    parameter int NUM_REGS      = 64,
    parameter int DATAW         = 128,
    parameter int STALL_TIMEOUT = 1023,
    // Derived widths; leave at their defaults.
    parameter int NW_BITS       = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int NR_BITS       = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [NW_BITS-1:0] in_wid,
    input  logic               in_wb,
    input  logic [NR_BITS-1:0] in_rd,
    input  logic [NR_BITS-1:0] in_rs1,
    input  logic [NR_BITS-1:0] in_rs2,
    input  logic [NR_BITS-1:0] in_rs3,
    input  logic [2:0]         in_use_rs,
    input  logic [DATAW-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NW_BITS-1:0] out_wid,
    output logic [DATAW-1:0]   out_data,
    input  logic               wb_valid,
    input  logic [NW_BITS-1:0] wb_wid,
    input  logic [NR_BITS-1:0] wb_rd,
    input  logic               wb_eop,
    output logic               stall_timeout,
    output logic [31:0]        perf_stalls
);

    localparam int                      c_stall_w   = $clog2(STALL_TIMEOUT + 1);
    localparam logic [c_stall_w-1:0]    c_stall_max = c_stall_w'(STALL_TIMEOUT);
    localparam logic [NUM_REGS-1:0]     c_reg_one   = NUM_REGS'(1);

    logic                   w_clr;
    logic [NUM_REGS-1:0]    w_rows [NUM_WARPS];
    logic [NUM_REGS-1:0]    w_row_bypass;
    logic                   w_hazard;
    logic                   w_ready;
    logic                   w_fire;

    logic                   r_out_valid;
    logic [NW_BITS-1:0]     r_out_wid;
    logic [DATAW-1:0]       r_out_data;
    logic [c_stall_w-1:0]   r_stall_cnt;
    logic                   r_stall_timeout;
    logic [31:0]            r_perf_stalls;

    assign w_clr = wb_valid && wb_eop;

    // Scoreboard row for the requesting warp with this cycle's release already
    // applied, so a waiter on the released register issues without a bubble.
    // Register 0 is hardwired zero and can never be busy.
    always_comb begin
        w_row_bypass = w_rows[in_wid];
        if (w_clr && (wb_wid == in_wid)) begin
            w_row_bypass = w_row_bypass & ~(c_reg_one << wb_rd);
        end
        w_row_bypass[0] = 1'b0;
    end

    assign w_hazard = in_valid && ((in_use_rs[0] && w_row_bypass[in_rs1]) ||
                                   (in_use_rs[1] && w_row_bypass[in_rs2]) ||
                                   (in_use_rs[2] && w_row_bypass[in_rs3]) ||
                                   (in_wb        && w_row_bypass[in_rd]));

    assign w_ready = !w_hazard && (!r_out_valid || out_ready);
    assign w_fire  = in_valid && w_ready;

    // Per-warp reservation rows. The set term is OR-ed after the clear so a
    // same-cycle reservation of a register being released keeps it busy.
    for (genvar gw = 0; gw < NUM_WARPS; gw++) begin : g_warp
        logic [NUM_REGS-1:0] r_inuse;
        logic [NUM_REGS-1:0] w_set;
        logic [NUM_REGS-1:0] w_clear;

        assign w_clear = (w_clr && (wb_wid == NW_BITS'(gw))) ? (c_reg_one << wb_rd) : '0;
        assign w_set   = (w_fire && in_wb && (in_rd != '0) && (in_wid == NW_BITS'(gw)))
                         ? (c_reg_one << in_rd) : '0;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_inuse <= '0;
            end else begin
                r_inuse <= (r_inuse & ~w_clear) | w_set;
            end
        end

        assign w_rows[gw] = r_inuse;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid     <= 1'b0;
            r_out_wid       <= '0;
            r_out_data      <= '0;
            r_stall_cnt     <= '0;
            r_stall_timeout <= 1'b0;
            r_perf_stalls   <= '0;
        end else begin
            if (w_fire) begin
                r_out_valid <= 1'b1;
                r_out_wid   <= in_wid;
                r_out_data  <= in_data;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Counts consecutive hazard stalls only; backpressure is not a
            // scoreboard stall and neither advances nor preserves the run.
            if (w_hazard) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
                if (r_stall_cnt != c_stall_max) begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end else begin
                r_stall_cnt <= '0;
            end

            if (r_stall_cnt == c_stall_max) begin
                r_stall_timeout <= 1'b1;
            end
        end
    end

    assign in_ready      = w_ready;
    assign out_valid     = r_out_valid;
    assign out_wid       = r_out_wid;
    assign out_data      = r_out_data;
    assign stall_timeout = r_stall_timeout;
    assign perf_stalls   = r_perf_stalls;

`ifndef SYNTHESIS
    // A stalled instruction must be held unchanged by the instruction buffer.
    a_in_hold : assert property (@(posedge clk) disable iff (!reset)
        (in_valid && !in_ready) |=> (in_valid &&
            $stable({in_wid, in_wb, in_rd, in_rs1, in_rs2, in_rs3, in_use_rs, in_data})));
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_issue_scoreboard
// Description : Self-checking bench for vx_issue_scoreboard. A behavioural
//               model (arrays of busy bits, plain counters) predicts every
//               output each cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_issue_scoreboard;

    localparam int NW = 4;
    localparam int NR = 64;
    localparam int DW = 128;
    localparam int ST = 1023;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_wid;
    logic          in_wb;
    logic [5:0]    in_rd, in_rs1, in_rs2, in_rs3;
    logic [2:0]    in_use_rs;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_wid;
    logic [DW-1:0] out_data;
    logic          wb_valid;
    logic [1:0]    wb_wid;
    logic [5:0]    wb_rd;
    logic          wb_eop;
    logic          stall_timeout;
    logic [31:0]   perf_stalls;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vx_issue_scoreboard #(
        .NUM_WARPS(NW), .NUM_REGS(NR), .DATAW(DW), .STALL_TIMEOUT(ST)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid), .in_wb(in_wb),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
        .in_use_rs(in_use_rs), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid), .out_data(out_data),
        .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
        .stall_timeout(stall_timeout), .perf_stalls(perf_stalls)
    );

    // ---------------- behavioural model ----------------
    bit          m_inuse [NW][NR];
    bit          m_ov;
    bit [1:0]    m_owid;
    bit [DW-1:0] m_odata;
    int          m_cnt;
    bit          m_to;
    bit [31:0]   m_perf;
    bit          m_known = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register busy as seen by the issue check: reserved, not r0, and not
    // being released this very cycle.
    function automatic bit busy(input int w, input int r);
        if (r == 0) return 1'b0;
        if (wb_valid && wb_eop && int'(wb_wid) == w && int'(wb_rd) == r) return 1'b0;
        return m_inuse[w][r];
    endfunction

    function automatic bit m_hazard();
        int w;
        if (!in_valid) return 1'b0;
        w = int'(in_wid);
        return (in_use_rs[0] && busy(w, int'(in_rs1))) ||
               (in_use_rs[1] && busy(w, int'(in_rs2))) ||
               (in_use_rs[2] && busy(w, int'(in_rs3))) ||
               (in_wb        && busy(w, int'(in_rd)));
    endfunction

    function automatic bit m_ready();
        return !m_hazard() && (!m_ov || out_ready);
    endfunction

    always @(posedge clk) begin : model_upd
        bit hz, fire;
        if (!reset) begin
            for (int w = 0; w < NW; w++)
                for (int r = 0; r < NR; r++)
                    m_inuse[w][r] <= 1'b0;
            m_ov    <= 1'b0;
            m_owid  <= '0;
            m_odata <= '0;
            m_cnt   <= 0;
            m_to    <= 1'b0;
            m_perf  <= '0;
            m_known <= 1'b1;
        end else begin
            hz   = m_hazard();
            fire = in_valid && m_ready();
            if (wb_valid && wb_eop) m_inuse[wb_wid][wb_rd] <= 1'b0;
            // issued after the clear so that a same-register reservation wins
            if (fire && in_wb && in_rd != 0) m_inuse[in_wid][in_rd] <= 1'b1;
            if (fire) begin
                m_ov    <= 1'b1;
                m_owid  <= in_wid;
                m_odata <= in_data;
            end else if (out_ready) begin
                m_ov <= 1'b0;
            end
            if (m_cnt == ST) m_to <= 1'b1;
            if (hz) begin
                m_perf <= m_perf + 1;
                m_cnt  <= (m_cnt < ST) ? m_cnt + 1 : ST;
            end else begin
                m_cnt <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("in_ready",      in_ready,      m_ready());
            chk("out_valid",     out_valid,     m_ov);
            chk("out_wid",       out_wid,       m_owid);
            chk("out_data",      out_data,      m_odata);
            chk("stall_timeout", stall_timeout, m_to);
            chk("perf_stalls",   perf_stalls,   m_perf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int wid, input bit wb, input int rd, input int rs1,
                         input int rs2, input int rs3, input bit [2:0] use_rs,
                         input bit [DW-1:0] data);
        in_valid  = 1'b1;
        in_wid    = 2'(wid);
        in_wb     = wb;
        in_rd     = 6'(rd);
        in_rs1    = 6'(rs1);
        in_rs2    = 6'(rs2);
        in_rs3    = 6'(rs3);
        in_use_rs = use_rs;
        in_data   = data;
    endtask

    task automatic release_reg(input int wid, input int rd);
        wb_valid = 1'b1;
        wb_eop   = 1'b1;
        wb_wid   = 2'(wid);
        wb_rd    = 6'(rd);
    endtask

    initial begin
        bit pend;
        bit fired;
        int nres, pick;

        reset = 1'b0; in_valid = 1'b0; in_wid = '0; in_wb = 1'b0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_rs3 = '0; in_use_rs = '0; in_data = '0;
        out_ready = 1'b1; wb_valid = 1'b0; wb_wid = '0; wb_rd = '0; wb_eop = 1'b0;

        cyc(); cyc();
        reset = 1'b1;
        cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_perf", perf_stalls, 0);
        chk("rst_timeout", stall_timeout, 0);

        // basic issue and reservation
        issue(0, 1, 5, 0, 0, 0, 3'b000, 128'h1111);
        #1 chk("issue_ready", in_ready, 1);
        cyc();
        chk("issue_out_valid", out_valid, 1);
        chk("issue_out_data", out_data, 128'h1111);
        chk("model_inuse_0_5", m_inuse[0][5], 1);

        // RAW stall, then zero-bubble wakeup on release
        issue(0, 0, 0, 5, 0, 0, 3'b001, 128'h2222);
        #1 chk("raw_stall", in_ready, 0);
        cyc(); cyc(); cyc();
        chk("raw_perf", perf_stalls, 3);
        release_reg(0, 5);
        #1 chk("bypass_ready", in_ready, 1);
        cyc();
        wb_valid = 1'b0; wb_eop = 1'b0;
        chk("bypass_out_data", out_data, 128'h2222);
        chk("model_inuse_0_5_clr", m_inuse[0][5], 0);

        // warp isolation
        issue(0, 1, 5, 0, 0, 0, 3'b000, 128'h3333);
        cyc();
        issue(1, 0, 0, 5, 0, 0, 3'b001, 128'h4444);
        #1 chk("warp_isolation", in_ready, 1);
        cyc();
        chk("warp_iso_out_wid", out_wid, 1);

        // register 0 never reserved
        issue(0, 1, 0, 0, 0, 0, 3'b000, 128'h5555);
        #1 chk("x0_wb_ready", in_ready, 1);
        cyc();
        issue(0, 0, 0, 0, 0, 0, 3'b001, 128'h6666);
        #1 chk("x0_read_ready", in_ready, 1);
        cyc();
        chk("x0_out_data", out_data, 128'h6666);

        // simultaneous release and reservation of the same register
        issue(2, 1, 7, 0, 0, 0, 3'b000, 128'h7777);
        cyc();
        issue(2, 1, 7, 7, 0, 0, 3'b001, 128'h8888);
        release_reg(2, 7);
        #1 chk("setclr_ready", in_ready, 1);
        cyc();
        wb_valid = 1'b0; wb_eop = 1'b0;
        chk("model_inuse_2_7", m_inuse[2][7], 1);
        issue(2, 0, 0, 7, 0, 0, 3'b001, 128'h9999);
        #1 chk("setclr_still_busy", in_ready, 0);
        release_reg(2, 7);
        cyc();
        wb_valid = 1'b0; wb_eop = 1'b0;
        in_valid = 1'b0;

        // backpressure holds output and is not a hazard stall
        issue(3, 0, 0, 0, 0, 0, 3'b000, 128'hAAAA);
        cyc();
        out_ready = 1'b0;
        issue(3, 0, 0, 0, 0, 0, 3'b000, 128'hBBBB);
        #1 chk("bp_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_out_data", out_data, 128'hAAAA);
        end
        chk("bp_perf", perf_stalls, 3);
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 1);
        cyc();
        chk("bp_next_data", out_data, 128'hBBBB);

        // stall timeout
        issue(1, 1, 9, 0, 0, 0, 3'b000, 128'hCCCC);
        cyc();
        issue(1, 0, 0, 9, 0, 0, 3'b001, 128'hDDDD);
        for (int i = 0; i < 1022; i++) cyc();
        chk("timeout_early", stall_timeout, 0);
        cyc(); cyc(); cyc();
        chk("timeout_set", stall_timeout, 1);
        chk("timeout_perf", perf_stalls, 3 + 1025);

        // mid-operation reset discards everything
        reset = 1'b0; in_valid = 1'b0;
        cyc();
        reset = 1'b1;
        chk("reset2_out_valid", out_valid, 0);
        chk("reset2_out_wid", out_wid, 0);
        chk("reset2_out_data", out_data, 0);
        chk("reset2_perf", perf_stalls, 0);
        chk("reset2_timeout", stall_timeout, 0);
        issue(1, 0, 0, 9, 0, 0, 3'b001, 128'hEEEE);
        #1 chk("reset2_resv_cleared", in_ready, 1);
        cyc();
        in_valid = 1'b0;

        // randomized traffic
        pend = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            wb_valid = 1'b0; wb_eop = 1'b0;
            if ($urandom_range(0, 9) < 4) begin
                nres = 0;
                for (int w = 0; w < NW; w++)
                    for (int r = 0; r < NR; r++)
                        if (m_inuse[w][r]) nres++;
                if (nres > 0) begin
                    pick = $urandom_range(0, nres - 1);
                    for (int w = 0; w < NW; w++)
                        for (int r = 0; r < NR; r++)
                            if (m_inuse[w][r]) begin
                                if (pick == 0) begin
                                    wb_wid = 2'(w);
                                    wb_rd  = 6'(r);
                                end
                                pick--;
                            end
                    wb_valid = 1'b1;
                    wb_eop   = ($urandom_range(0, 9) < 7);
                end
            end else if ($urandom_range(0, 9) == 0) begin
                wb_valid = 1'b1;
                wb_eop   = 1'b1;
                wb_wid   = 2'($urandom_range(0, NW - 1));
                wb_rd    = 6'($urandom_range(0, 7));
            end

            if ($urandom_range(0, 599) == 0) begin
                reset    = 1'b0;
                in_valid = 1'b0;
                pend     = 1'b0;
            end else begin
                reset = 1'b1;
                if (!pend) begin
                    if ($urandom_range(0, 3) != 0) begin
                        issue($urandom_range(0, NW - 1), 1'($urandom_range(0, 1)),
                              $urandom_range(0, 7), $urandom_range(0, 7),
                              $urandom_range(0, 7), $urandom_range(0, 7),
                              3'($urandom_range(0, 7)),
                              {$urandom, $urandom, $urandom, $urandom});
                        pend = 1'b1;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            fired = reset && in_valid && m_ready();
            cyc();
            if (fired) pend = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
